// File: rtl/serial_pattern_tx_if.sv
// Handshake/bus bundle between a pattern source and the serial transmitter.
interface serial_pattern_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] pattern;
  logic [3:0]       len;
  logic             start;
  logic             repeat_en;
  logic             abort;
  logic             w;
  logic             valid;
  logic             busy;
  logic             done;
  logic [2:0]       leds;

  // Pattern source side.
  modport master (
    output load, pattern, len, start, repeat_en, abort,
    input  w, valid, busy, done, leds
  );

  // Transmitter side.
  modport slave (
    input  load, pattern, len, start, repeat_en, abort,
    output w, valid, busy, done, leds
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: loads a pattern and length, shifts it out LSB
// first one bit per clock, optionally repeating with a one-cycle gap.
module serial_pattern_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  serial_pattern_tx_if.slave  bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LOADED = 3'b001,
    S_SEND   = 3'b010,
    S_GAP    = 3'b011,
    S_DONE   = 3'b100
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_reg;
  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] len_reg;
  logic [CNT_W-1:0] cnt;
  logic             w_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] len_clamp;
  logic             load_ok;

  // Lengths beyond the register width clamp to the full width.
  assign len_clamp = (bus.len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.len;
  assign load_ok   = bus.load && (bus.len != '0);

  // Transmitter FSM with datapath; outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pat_reg <= '0;
      shift   <= '0;
      len_reg <= '0;
      cnt     <= '0;
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_ok) begin
            pat_reg <= bus.pattern;
            len_reg <= len_clamp;
            state   <= S_LOADED;
          end
        end
        S_LOADED: begin
          if (load_ok) begin
            pat_reg <= bus.pattern;
            len_reg <= len_clamp;
          end else if (bus.start && !bus.load) begin
            shift   <= pat_reg;
            cnt     <= len_reg;
            w_q     <= pat_reg[0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.abort) begin
            state <= S_LOADED;
          end else if (cnt == CNT_W'(1)) begin
            cnt    <= '0;
            busy_q <= 1'b1;
            if (bus.repeat_en) begin
              state <= S_GAP;
            end else begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end else begin
            shift   <= shift >> 1;
            cnt     <= cnt - CNT_W'(1);
            w_q     <= shift[1];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_GAP: begin
          if (bus.abort) begin
            state <= S_LOADED;
          end else begin
            shift   <= pat_reg;
            cnt     <= len_reg;
            w_q     <= pat_reg[0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state   <= S_SEND;
          end
        end
        S_DONE: begin
          // Pattern is retained so the source may restart without reloading.
          state <= S_LOADED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.w     = w_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.leds  = 3'(state);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed self-checking bench for serial_pattern_tx.
module tb_serial_pattern_tx;
  localparam int unsigned WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  serial_pattern_tx_if #(.WIDTH(WIDTH)) bus ();

  serial_pattern_tx #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.load      = 1'b0;
    bus.pattern   = '0;
    bus.len       = '0;
    bus.start     = 1'b0;
    bus.repeat_en = 1'b0;
    bus.abort     = 1'b0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] p, input logic [3:0] l);
    bus.load    = 1'b1;
    bus.pattern = p;
    bus.len     = l;
    step();
    bus.load    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.leds !== 3'b000 || bus.w !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: leds=%b w=%b valid=%b busy=%b, required leds=000 w=0 valid=0 busy=0",
                 i, bus.leds, bus.w, bus.valid, bus.busy);
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_send8();
    logic [7:0] pat;
    pat = 8'b1011_0010;
    do_load(pat, 4'd8);
    checks++;
    if (bus.leds !== 3'b001) begin
      errors++;
      $display("FAIL send8_loaded: leds=%b required 001", bus.leds);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.w !== pat[i] || bus.valid !== 1'b1 || bus.busy !== 1'b1 || bus.leds !== 3'b010) begin
        errors++;
        $display("FAIL send8_bit %0d: w=%b valid=%b busy=%b leds=%b, required w=%b valid=1 busy=1 leds=010",
                 i, bus.w, bus.valid, bus.busy, bus.leds, pat[i]);
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.leds !== 3'b100 || bus.valid !== 1'b0 || bus.w !== 1'b0) begin
      errors++;
      $display("FAIL send8_done: done=%b leds=%b valid=%b w=%b, required done=1 leds=100 valid=0 w=0",
               bus.done, bus.leds, bus.valid, bus.w);
    end
    step();
    checks++;
    if (bus.leds !== 3'b001 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL send8_back_loaded: leds=%b done=%b busy=%b, required leds=001 done=0 busy=0",
               bus.leds, bus.done, bus.busy);
    end
  endtask

  task automatic test_repeat();
    do_load(8'h0F, 4'd4);
    bus.repeat_en = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (bus.w !== 1'b1 || bus.valid !== 1'b1 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL repeat_bit pass %0d bit %0d: w=%b valid=%b done=%b, required w=1 valid=1 done=0",
                   pass, i, bus.w, bus.valid, bus.done);
        end
        if (pass == 2 && i == 0) bus.repeat_en = 1'b0;
        step();
      end
      if (pass < 2) begin
        checks++;
        if (bus.w !== 1'b0 || bus.valid !== 1'b0 || bus.leds !== 3'b011 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL repeat_gap pass %0d: w=%b valid=%b leds=%b busy=%b, required w=0 valid=0 leds=011 busy=1",
                   pass, bus.w, bus.valid, bus.leds, bus.busy);
        end
        step();
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.leds !== 3'b100) begin
      errors++;
      $display("FAIL repeat_done: done=%b leds=%b, required done=1 leds=100", bus.done, bus.leds);
    end
    step();
  endtask

  task automatic test_abort();
    logic [7:0] pat;
    int         done_seen;
    pat = 8'b1011_0010;
    done_seen = 0;
    do_load(pat, 4'd8);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    bus.abort = 1'b1;
    if (bus.done === 1'b1) done_seen++;
    step();
    bus.abort = 1'b0;
    checks++;
    if (bus.leds !== 3'b001 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: leds=%b valid=%b busy=%b, required leds=001 valid=0 busy=0",
               bus.leds, bus.valid, bus.busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.done === 1'b1) done_seen++;
      step();
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d required 0", done_seen);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.w !== pat[i] || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL abort_resend bit %0d: w=%b valid=%b, required w=%b valid=1",
                 i, bus.w, bus.valid, pat[i]);
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL abort_resend_done: done=%b required 1", bus.done);
    end
    step();
  endtask

  task automatic test_load_rules();
    logic [7:0] pat;
    pat = 8'h3C;
    reset = 1'b1;
    step();
    reset = 1'b0;
    do_load(8'hFF, 4'd0);
    checks++;
    if (bus.leds !== 3'b000) begin
      errors++;
      $display("FAIL load_len0: leds=%b required 000", bus.leds);
    end
    do_load(8'hA5, 4'd8);
    bus.load    = 1'b1;
    bus.pattern = pat;
    bus.len     = 4'd12;
    bus.start   = 1'b1;
    step();
    bus.load  = 1'b0;
    bus.start = 1'b0;
    checks++;
    if (bus.leds !== 3'b001 || bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_start_prio: leds=%b valid=%b busy=%b, required leds=001 valid=0 busy=0",
               bus.leds, bus.valid, bus.busy);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.w !== pat[i] || bus.valid !== 1'b1) begin
        errors++;
        $display("FAIL clamp_bit %0d: w=%b valid=%b, required w=%b valid=1", i, bus.w, bus.valid, pat[i]);
      end
      step();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL clamp_done: done=%b valid=%b, required done=1 valid=0", bus.done, bus.valid);
    end
    step();
  endtask

  task automatic test_len1();
    do_load(8'h01, 4'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.w !== 1'b1 || bus.valid !== 1'b1 || bus.leds !== 3'b010) begin
      errors++;
      $display("FAIL len1_bit: w=%b valid=%b leds=%b, required w=1 valid=1 leds=010", bus.w, bus.valid, bus.leds);
    end
    step();
    checks++;
    if (bus.done !== 1'b1 || bus.leds !== 3'b100) begin
      errors++;
      $display("FAIL len1_done: done=%b leds=%b, required done=1 leds=100", bus.done, bus.leds);
    end
    step();
  endtask

  task automatic test_reset_mid_send();
    do_load(8'hFF, 4'd8);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.leds !== 3'b000 || bus.w !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_send: leds=%b w=%b valid=%b busy=%b done=%b, required all 0",
               bus.leds, bus.w, bus.valid, bus.busy, bus.done);
    end
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.leds !== 3'b000 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
        errors++;
        $display("FAIL start_no_load cyc %0d: leds=%b busy=%b valid=%b, required leds=000 busy=0 valid=0",
                 i, bus.leds, bus.busy, bus.valid);
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_send8();
    test_repeat();
    test_abort();
    test_load_rules();
    test_len1();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-stream transmitter that drives the single-bit `w` input of the sequence-detector FSMs in the lab designs. A parallel pattern and a bit count are loaded, then shifted out one bit per clock, LSB first, with an optional gapped repeat mode. State is exposed on `leds` so the board shows transmitter activity the same way the detectors show theirs. Built from a binary-encoded 3-bit state register, a shift register and a down-counter.

## Interface
- `WIDTH`, 8: maximum pattern length in bits (2..15).
- `clk`  input  1  rising-edge clock for all state.
- `reset`  input  1  synchronous, active-high reset; one clock, one reset, no other clock domains.
- `load`  input  1  capture `pattern`/`len` on this edge (IDLE or LOADED only).
- `pattern`  input  WIDTH  bits to send, bit 0 first.
- `len`  input  4  number of bits to send; 0 = load rejected; >WIDTH clamps to WIDTH.
- `start`  input  1  begin transmission (LOADED only).
- `repeat_en`  input  1  sampled at end of each pass; 1 = resend after one gap cycle.
- `abort`  input  1  terminate transmission, return to LOADED.
- `w`  output  1  serial data to detector; 0 whenever `valid`=0.
- `valid`  output  1  `w` carries a pattern bit this cycle.
- `busy`  output  1  high in SEND, GAP, DONE.
- `done`  output  1  one-cycle pulse at completion of a non-repeated pass.
- `leds`  output  3  current state encoding.

## Operation
- States (binary, on `leds`): IDLE=000, LOADED=001, SEND=010, GAP=011, DONE=100. Codes 101-111 illegal; next state from any illegal code is IDLE.
- IDLE: `load` with `len`≠0 -> store pattern in `pat_reg`, clamped length in `len_reg`, go LOADED. `start`, `abort` ignored.
- LOADED: `load` (`len`≠0) reloads registers, stays LOADED; `load` has priority over a simultaneous `start`. `start` alone -> copy `pat_reg` to shift register, `cnt`=`len_reg`, go SEND.
- SEND: `w`=shift[0], `valid`=1. Each cycle shift right by 1, `cnt` decrements. On the cycle `cnt`=1 (last bit): `repeat_en`=1 -> GAP, else -> DONE.
- GAP: `w`=0, `valid`=0 for exactly one cycle; shift register reloaded from `pat_reg`, `cnt`=`len_reg`; go SEND.
- DONE: `done`=1 for one cycle; go LOADED (pattern retained, may `start` again without reload).
- `abort` in SEND/GAP/DONE -> LOADED next edge, highest priority after reset; `done` not asserted on abort.
- `load`/`start` in SEND/GAP/DONE ignored; `pat_reg`/`len_reg` unchanged while busy.
- `busy` = state ∈ {SEND, GAP, DONE}. `w`, `valid`, `busy`, `done` decoded from registered state/shift register only (no input-to-output combinational path).

## Timing
- Reset (edge with `reset`=1): state=IDLE, shift, `pat_reg`, `cnt`=0, `len_reg`=0. Outputs after reset: `w`=0, `valid`=0, `busy`=0, `done`=0, `leds`=000. Reset mid-transmission aborts immediately with no `done`.
- `start` sampled high at edge k: bit i of pattern on `w` during cycle k+1+i, i=0..len-1.
- Non-repeat: `done`=1 during cycle k+1+len; state LOADED at cycle k+2+len. Earliest re-`start` at that cycle's edge.
- Repeat: gap at cycle k+1+len, bit 0 of next pass at k+2+len; pass period = len+1 cycles.
- `repeat_en` sampled only on the last-bit cycle; deasserting it mid-pass ends after the current pass.
- `len`=1: single-bit pass; SEND lasts one cycle.

## Test plan
- Reset, then idle 5 cycles with `start`=1 -> `leds`=000, `w`=0, `valid`=0, `busy`=0 throughout.
- Load `pattern`=8'b1011_0010, `len`=8, `start` at edge k -> `w` = 0,1,0,0,1,1,0,1 on cycles k+1..k+8, `done`=1 at k+9, `leds`=001 at k+10.
- `len`=4, `pattern`=8'h0F, `repeat_en`=1 for 3 passes -> `w` = 1111,0(gap),1111,0,1111; `valid` low only on gap cycles; clear `repeat_en` during pass 3 -> `done` after pass 3.
- `abort` on 3rd bit of `len`=8 pass -> `leds`=001 next cycle, `done` never asserted, re-`start` resends full original pattern.
- `load` with `len`=0 in IDLE -> stays 000; `load`+`start` same edge in LOADED -> new pattern captured, stays LOADED; `len`=12 -> 8 bits sent.
- Assert `reset` mid-SEND -> next cycle all outputs 0, `leds`=000; `start` without prior `load` ignored.
